// File: rtl/ysyx_writeback_unit_if.sv
// rtl/ysyx_writeback_unit_if.sv - writeback request and register-file write bundle
interface ysyx_writeback_unit_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          exu_valid;
   logic          exu_ready;
   logic [AW-1:0] exu_rd;
   logic [DW-1:0] exu_data;
   logic          lsu_valid;
   logic          lsu_ready;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_data;
   logic          rf_wr_en;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   // Sources and register file as seen from outside the unit
   modport master (
      output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
      input  exu_ready, lsu_ready, rf_wr_en, rf_waddr, rf_wdata
   );

   // The writeback unit itself
   modport slave (
      input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
      output exu_ready, lsu_ready, rf_wr_en, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/ysyx_writeback_unit.sv
// rtl/ysyx_writeback_unit.sv - EXU/LSU writeback merge FIFO driving the register file write port; optional trace via YSYX_WB_TRACE_EN
module ysyx_writeback_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ysyx_writeback_unit_if.slave     wb,
   input  logic                     wb_hold,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              retire_cnt,
   output logic                     idle
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] rd_mem   [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          last_lsu;    // 1 when the LSU won the most recent handshake

   logic          full;
   logic          empty;
   logic          grant_exu;
   logic          grant_lsu;
   logic          exu_hs;
   logic          lsu_hs;
   logic          push;
   logic          pop;
   logic [AW-1:0] push_rd;
   logic [DW-1:0] push_data;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Round-robin grant: on a tie the source that did not win last time goes
   always_comb begin
      grant_exu = 1'b0;
      grant_lsu = 1'b0;
      if (wb.exu_valid && wb.lsu_valid) begin
         grant_exu = last_lsu;
         grant_lsu = !last_lsu;
      end else begin
         grant_exu = wb.exu_valid;
         grant_lsu = wb.lsu_valid;
      end
   end

   // Readies depend only on grant and occupancy, never on a same-cycle pop
   assign wb.exu_ready = rst_n && grant_exu && !full;
   assign wb.lsu_ready = rst_n && grant_lsu && !full;
   assign exu_hs       = wb.exu_valid && wb.exu_ready;
   assign lsu_hs       = wb.lsu_valid && wb.lsu_ready;
   assign push_rd      = exu_hs ? wb.exu_rd   : wb.lsu_rd;
   assign push_data    = exu_hs ? wb.exu_data : wb.lsu_data;

   // x0 writes complete their handshake but are never buffered
   assign push = (exu_hs || lsu_hs) && (push_rd != '0);
   assign pop  = !empty && !wb_hold;

   assign wb.rf_wr_en = pop;
   assign wb.rf_waddr = pop ? rd_mem[rd_ptr]   : '0;
   assign wb.rf_wdata = pop ? data_mem[rd_ptr] : '0;

   assign fifo_count = count;
   assign idle       = empty && !wb.exu_valid && !wb.lsu_valid;

   // Pointers, occupancy, arbitration history and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         last_lsu   <= 1'b1;
         retire_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            retire_cnt <= retire_cnt + 32'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (exu_hs) begin
            last_lsu <= 1'b0;
         end else if (lsu_hs) begin
            last_lsu <= 1'b1;
         end
      end
   end

   // Entry storage needs no reset; count alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= push_rd;
         data_mem[wr_ptr] <= push_data;
      end
   end

`ifdef YSYX_WB_TRACE_EN
   // Simulation trace of register file writes and discarded x0 writes
   always @(posedge clk) begin
      if (wb.rf_wr_en) begin
         $display("wb x%0d <= 0x%08h", wb.rf_waddr, wb.rf_wdata);
      end
      if ((exu_hs || lsu_hs) && (push_rd == '0)) begin
         $display("wb x0 drop");
      end
   end
`else
`endif

endmodule

// File: tb/tb_ysyx_writeback_unit.sv
// tb/tb_ysyx_writeback_unit.sv - scoreboard bench for ysyx_writeback_unit
module tb_ysyx_writeback_unit;
   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_hold = 1'b0;
   logic [2:0]  fifo_count;
   logic [31:0] retire_cnt;
   logic        idle;

   ysyx_writeback_unit_if #(.AW(AW), .DW(DW)) wb();

   ysyx_writeback_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb         (wb),
      .wb_hold    (wb_hold),
      .fifo_count (fifo_count),
      .retire_cnt (retire_cnt),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int            cmp_cnt = 0;
   int            err_cnt = 0;
   logic [36:0]   exp_q[$];
   logic [36:0]   sb_e;
   int            m_cnt = 0;
   logic          exp_last = 1'b1;
   int unsigned   exp_retire = 0;

   // Scoreboard consumer: every register file write must match the oldest expectation
   always @(negedge clk) begin
      #2;
      if (wb.rf_wr_en) begin
         cmp_cnt++;
         if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL sb_unexpected: got write x%0d=0x%08h required no write", wb.rf_waddr, wb.rf_wdata);
         end else begin
            sb_e = exp_q.pop_front();
            if ({wb.rf_waddr, wb.rf_wdata} !== sb_e) begin
               err_cnt++;
               $display("FAIL sb_write: got x%0d=0x%08h required x%0d=0x%08h",
                        wb.rf_waddr, wb.rf_wdata, sb_e[36:32], sb_e[31:0]);
            end
         end
      end
   end

   function automatic logic [1:0] exp_grant();
      logic e, l;
      if (wb.exu_valid && wb.lsu_valid) begin
         e = exp_last;
         l = !exp_last;
      end else begin
         e = wb.exu_valid;
         l = wb.lsu_valid;
      end
      if (m_cnt >= DEPTH || !rst_n) return 2'b00;
      return {e, l};
   endfunction

   task automatic model_commit(input logic [1:0] g);
      logic p_pop, p_push;
      p_pop  = (m_cnt > 0) && !wb_hold;
      p_push = 1'b0;
      if (g[1]) begin
         exp_last = 1'b0;
         if (wb.exu_rd != 0) begin
            p_push = 1'b1;
            exp_q.push_back({wb.exu_rd, wb.exu_data});
         end
      end else if (g[0]) begin
         exp_last = 1'b1;
         if (wb.lsu_rd != 0) begin
            p_push = 1'b1;
            exp_q.push_back({wb.lsu_rd, wb.lsu_data});
         end
      end
      if (p_pop) exp_retire++;
      m_cnt = m_cnt + int'(p_push) - int'(p_pop);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
         model_commit(exp_grant());
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wb.exu_valid = 1'b0;
      wb.lsu_valid = 1'b0;
      wb_hold = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      exp_last = 1'b1;
      exp_retire = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wb.exu_valid = 1'b1; wb.exu_rd = 5'd3; wb.exu_data = 32'h1;
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_data = 32'h2;
      repeat (2) @(negedge clk);
      #1;
      cmp_cnt++; if (wb.exu_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_exu_ready: got %0b required 0", wb.exu_ready); end
      cmp_cnt++; if (wb.lsu_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_lsu_ready: got %0b required 0", wb.lsu_ready); end
      cmp_cnt++; if (wb.rf_wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rf_wr_en: got %0b required 0", wb.rf_wr_en); end
      cmp_cnt++; if ({wb.rf_waddr, wb.rf_wdata} !== 37'd0) begin err_cnt++; $display("FAIL reset_rf_bus: got %0h required 0", {wb.rf_waddr, wb.rf_wdata}); end
      cmp_cnt++; if (fifo_count !== 3'd0) begin err_cnt++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
      cmp_cnt++; if (retire_cnt !== 32'd0) begin err_cnt++; $display("FAIL reset_retire: got %0d required 0", retire_cnt); end
      wb.exu_valid = 1'b0;
      wb.lsu_valid = 1'b0;
      #1;
      cmp_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL reset_idle: got %0b required 1", idle); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [1:0] g;
      @(negedge clk);
      wb.exu_valid = 1'b1; wb.exu_rd = 5'd5; wb.exu_data = 32'h1234;
      #1;
      g = exp_grant();
      cmp_cnt++; if (wb.exu_ready !== 1'b1) begin err_cnt++; $display("FAIL single_ready: got %0b required 1", wb.exu_ready); end
      cmp_cnt++; if (wb.rf_wr_en !== 1'b0) begin err_cnt++; $display("FAIL single_no_bypass: got %0b required 0", wb.rf_wr_en); end
      model_commit(g);
      @(negedge clk);
      wb.exu_valid = 1'b0;
      #1;
      cmp_cnt++; if ({wb.rf_wr_en, wb.rf_waddr, wb.rf_wdata} !== {1'b1, 5'd5, 32'h1234})
         begin err_cnt++; $display("FAIL single_write: got en=%0b x%0d=0x%08h required en=1 x5=0x00001234", wb.rf_wr_en, wb.rf_waddr, wb.rf_wdata); end
      model_commit(exp_grant());
      idle_cycles(2);
      cmp_cnt++; if (retire_cnt !== 32'd1) begin err_cnt++; $display("FAIL single_retire: got %0d required 1", retire_cnt); end
   endtask

   task automatic test_arbitration();
      logic [1:0] g;
      apply_reset();
      wb.exu_rd = 5'd1; wb.exu_data = 32'hE000_0001;
      wb.lsu_rd = 5'd2; wb.lsu_data = 32'h1500_0002;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wb.exu_valid = 1'b1;
         wb.lsu_valid = 1'b1;
         #1;
         g = exp_grant();
         cmp_cnt++; if ({wb.exu_ready, wb.lsu_ready} !== g)
            begin err_cnt++; $display("FAIL arb_grant[%0d]: got %b required %b", i, {wb.exu_ready, wb.lsu_ready}, g); end
         cmp_cnt++; if (wb.exu_ready !== ((i % 2) == 0))
            begin err_cnt++; $display("FAIL arb_alternate[%0d]: got exu_ready=%0b required %0b", i, wb.exu_ready, (i % 2) == 0); end
         model_commit(g);
      end
      @(negedge clk);
      wb.exu_valid = 1'b0;
      wb.lsu_valid = 1'b0;
      #1;
      model_commit(exp_grant());
      idle_cycles(3);
      cmp_cnt++; if (retire_cnt !== exp_retire) begin err_cnt++; $display("FAIL arb_retire: got %0d required %0d", retire_cnt, exp_retire); end
   endtask

   task automatic test_hold_fill();
      logic [1:0] g;
      logic [4:0] nr;
      nr = 5'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         wb_hold = 1'b1;
         wb.exu_valid = 1'b1; wb.exu_rd = nr; wb.exu_data = 32'hA0 + 32'(nr);
         #1;
         g = exp_grant();
         cmp_cnt++; if (wb.exu_ready !== g[1]) begin err_cnt++; $display("FAIL hold_ready[%0d]: got %0b required %0b", i, wb.exu_ready, g[1]); end
         cmp_cnt++; if (fifo_count !== 3'(m_cnt)) begin err_cnt++; $display("FAIL hold_count[%0d]: got %0d required %0d", i, fifo_count, m_cnt); end
         if (i == 4) begin
            cmp_cnt++; if ({fifo_count, wb.exu_ready} !== {3'd4, 1'b0})
               begin err_cnt++; $display("FAIL hold_full: got count=%0d ready=%0b required count=4 ready=0", fifo_count, wb.exu_ready); end
         end
         model_commit(g);
         if (g[1]) nr = nr + 5'd1;
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         wb.exu_valid = 1'b0;
         wb_hold = 1'b0;
         #1;
         cmp_cnt++; if ({wb.rf_wr_en, wb.rf_waddr} !== {1'b1, 5'(k)})
            begin err_cnt++; $display("FAIL hold_drain[%0d]: got en=%0b x%0d required en=1 x%0d", k, wb.rf_wr_en, wb.rf_waddr, k); end
         model_commit(exp_grant());
      end
      idle_cycles(2);
      cmp_cnt++; if (fifo_count !== 3'd0) begin err_cnt++; $display("FAIL hold_empty: got %0d required 0", fifo_count); end
   endtask

   task automatic test_x0_drop();
      logic [1:0] g;
      @(negedge clk);
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd0; wb.lsu_data = 32'hDEAD;
      #1;
      g = exp_grant();
      cmp_cnt++; if (wb.lsu_ready !== 1'b1) begin err_cnt++; $display("FAIL x0_ready: got %0b required 1", wb.lsu_ready); end
      model_commit(g);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wb.lsu_valid = 1'b0;
         #1;
         cmp_cnt++; if ({fifo_count, wb.rf_wr_en} !== 4'd0)
            begin err_cnt++; $display("FAIL x0_nowrite[%0d]: got count=%0d en=%0b required 0/0", i, fifo_count, wb.rf_wr_en); end
         model_commit(exp_grant());
      end
      cmp_cnt++; if (retire_cnt !== exp_retire) begin err_cnt++; $display("FAIL x0_retire: got %0d required %0d", retire_cnt, exp_retire); end
   endtask

   task automatic test_full_drain();
      logic [1:0] g;
      logic [4:0] nr;
      nr = 5'd6;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         wb_hold = (i < 4);
         wb.exu_valid = 1'b1; wb.exu_rd = nr; wb.exu_data = 32'hF00 + 32'(nr);
         #1;
         g = exp_grant();
         cmp_cnt++; if (wb.exu_ready !== g[1]) begin err_cnt++; $display("FAIL full_ready[%0d]: got %0b required %0b", i, wb.exu_ready, g[1]); end
         cmp_cnt++; if (fifo_count !== 3'(m_cnt) || fifo_count > 3'd4)
            begin err_cnt++; $display("FAIL full_count[%0d]: got %0d required %0d", i, fifo_count, m_cnt); end
         model_commit(g);
         if (g[1]) nr = nr + 5'd1;
      end
      @(negedge clk);
      wb.exu_valid = 1'b0;
      #1;
      model_commit(exp_grant());
      idle_cycles(5);
      cmp_cnt++; if (retire_cnt !== exp_retire) begin err_cnt++; $display("FAIL full_retire: got %0d required %0d", retire_cnt, exp_retire); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] g;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wb_hold = 1'b1;
         wb.exu_valid = 1'b1; wb.exu_rd = 5'(11 + i); wb.exu_data = 32'hC0 + 32'(i);
         #1;
         g = exp_grant();
         model_commit(g);
      end
      @(negedge clk);
      wb.exu_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      exp_last = 1'b1;
      exp_retire = 0;
      #1;
      cmp_cnt++; if ({fifo_count, wb.rf_wr_en} !== 4'd0)
         begin err_cnt++; $display("FAIL rstmid_async: got count=%0d en=%0b required 0/0", fifo_count, wb.rf_wr_en); end
      wb_hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         cmp_cnt++; if (wb.rf_wr_en !== 1'b0) begin err_cnt++; $display("FAIL rstmid_nowrite[%0d]: got %0b required 0", i, wb.rf_wr_en); end
         model_commit(exp_grant());
      end
      @(negedge clk);
      wb.exu_valid = 1'b1; wb.exu_rd = 5'd14; wb.exu_data = 32'h5A5A_0014;
      #1;
      g = exp_grant();
      cmp_cnt++; if (wb.exu_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_push: got %0b required 1", wb.exu_ready); end
      model_commit(g);
      @(negedge clk);
      wb.exu_valid = 1'b0;
      #1;
      model_commit(exp_grant());
      idle_cycles(2);
      cmp_cnt++; if (retire_cnt !== 32'd1) begin err_cnt++; $display("FAIL rstmid_retire: got %0d required 1", retire_cnt); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      wb.exu_valid = 1'b0; wb.exu_rd = '0; wb.exu_data = '0;
      wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
      test_reset();
      test_single();
      test_arbitration();
      test_hold_fill();
      test_x0_drop();
      test_full_drain();
      test_reset_mid();
      cmp_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL sb_drained: got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
